vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arb_pkg.sv | 21 ++
 rtl/vram_arb_stall_ctr.sv | 25 ++
 rtl/vram_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: slot owner tags, CPU FSM
// states and pipeline/statistic widths.
package vram_arb_pkg;

    localparam int PIPE_LAT = 3;
    localparam int STALL_W  = 16;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_DISP   = 2'd1,
        OWN_CPU_RD = 2'd2,
        OWN_CPU_WR = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_BUSY = 2'd1,
        CPU_ACK  = 2'd2
    } cpu_state_e;

endpackage

// File: rtl/vram_arb_stall_ctr.sv
// Saturating counter of cycles in which an idle CPU request was refused a slot.
module vram_arb_stall_ctr
    import vram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    output logic [STALL_W-1:0] count
);

    logic [STALL_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {STALL_W{1'b1}})) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches have absolute priority over CPU
// accesses; every slot is tagged and completes a fixed 3 cycles after grant.
// Optional CPU stall statistic enabled by defining VRAM_ARB_STALL_CNT_EN.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic [DATA_W-1:0]  disp_data,
    output logic               disp_valid,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ack,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [STALL_W-1:0] stall_count
);

    cpu_state_e        state_q;
    logic              cpu_ack_q;
    logic              cpu_grant;
    owner_e            grant_own;
    owner_e            tag1_d, tag1_q, tag2_d, tag2_q, tag3_d, tag3_q;
    logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
    logic              ram_we_d, ram_we_q;
    logic [DATA_W-1:0] ram_wdata_d, ram_wdata_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              disp_valid_d, disp_valid_q;
    logic [DATA_W-1:0] disp_data_d, disp_data_q;
    logic [DATA_W-1:0] cpu_rdata_d, cpu_rdata_q;

    always_comb begin
        cpu_grant = cpu_req && !disp_req && (state_q == CPU_IDLE);
        grant_own = OWN_NONE;
        if (disp_req)       grant_own = OWN_DISP;
        else if (cpu_grant) grant_own = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    end

    // Idle slots keep the last address/data so the RAM bus only toggles on use.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        if (disp_req) begin
            ram_addr_d = disp_addr;
        end else if (cpu_grant) begin
            ram_addr_d = cpu_addr;
            ram_we_d   = cpu_we;
            if (cpu_we) ram_wdata_d = cpu_wdata;
        end
        tag1_d       = grant_own;
        tag2_d       = tag1_q;
        tag3_d       = tag2_q;
        rdata_d      = (tag2_q != OWN_NONE) ? ram_rdata : rdata_q;
        disp_valid_d = (tag3_q == OWN_DISP);
        disp_data_d  = (tag3_q == OWN_DISP)   ? rdata_q : disp_data_q;
        cpu_rdata_d  = (tag3_q == OWN_CPU_RD) ? rdata_q : cpu_rdata_q;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            tag1_q       <= OWN_NONE;
            tag2_q       <= OWN_NONE;
            tag3_q       <= OWN_NONE;
            rdata_q      <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            tag3_q       <= tag3_d;
            rdata_q      <= rdata_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    // The ACK state blocks a regrant while the requester is still seeing its ack.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CPU_IDLE;
            cpu_ack_q <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            case (state_q)
                CPU_IDLE: if (cpu_grant) state_q <= CPU_BUSY;
                CPU_BUSY: begin
                    if ((tag3_q == OWN_CPU_RD) || (tag3_q == OWN_CPU_WR)) begin
                        state_q   <= CPU_ACK;
                        cpu_ack_q <= 1'b1;
                    end
                end
                CPU_ACK:  state_q <= CPU_IDLE;
                default:  state_q <= CPU_IDLE;
            endcase
        end
    end

`ifdef VRAM_ARB_STALL_CNT_EN
    logic stall_inc;
    assign stall_inc = cpu_req && !cpu_grant && (state_q == CPU_IDLE);

    vram_arb_stall_ctr u_stall_ctr (
        .clk   (clk_pixel),
        .rst_n (reset_n),
        .inc   (stall_inc),
        .count (stall_count)
    );
`else
    assign stall_count = '0;
`endif

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios followed by random
// traffic, compared cycle by cycle against a slot-schedule reference model.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int NC = 4096;

    logic          clk_pixel = 1'b0;
    logic          reset_n   = 1'b0;
    logic          disp_req  = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          cpu_req   = 1'b0;
    logic          cpu_we    = 1'b0;
    logic [AW-1:0] cpu_addr  = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [15:0]   stall_count;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .stall_count (stall_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Synchronous single-port RAM: data appears one cycle after the command.
    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: 8'h00};
    always @(posedge clk_pixel) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a schedule of expected completions indexed by cycle.
    logic [DW-1:0] model_mem [0:(1<<AW)-1] = '{default: 8'h00};
    bit            exp_dv     [0:NC-1];
    logic [DW-1:0] exp_dd_at  [0:NC-1];
    bit            exp_ack    [0:NC-1];
    bit            exp_ack_rd [0:NC-1];
    logic [DW-1:0] exp_rd_at  [0:NC-1];
    logic [DW-1:0] exp_ddata, exp_crdata, exp_wdata;
    logic [AW-1:0] exp_addr;
    bit            exp_we_now;
    int            cpu_free;
    int            exp_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            exp_dv[i] = 1'b0; exp_ack[i] = 1'b0; exp_ack_rd[i] = 1'b0;
        end
        exp_ddata = '0; exp_crdata = '0; exp_addr = '0; exp_wdata = '0;
        exp_we_now = 1'b0; cpu_free = 0; exp_stall = 0;
    endtask

    // Applies the arbitration rules to the inputs sampled at this edge.
    task automatic model_edge();
        cyc++;
        exp_we_now = 1'b0;
        if (!reset_n) return;
        if (disp_req) begin
            exp_dv[cyc+3]    = 1'b1;
            exp_dd_at[cyc+3] = model_mem[disp_addr];
            exp_addr         = disp_addr;
            if (cpu_req && cyc >= cpu_free) begin
`ifdef VRAM_ARB_STALL_CNT_EN
                if (exp_stall < 65535) exp_stall++;
`endif
            end
        end else if (cpu_req && cyc >= cpu_free) begin
            exp_addr       = cpu_addr;
            exp_ack[cyc+3] = 1'b1;
            cpu_free       = cyc + 5;
            if (cpu_we) begin
                model_mem[cpu_addr] = cpu_wdata;
                exp_we_now = 1'b1;
                exp_wdata  = cpu_wdata;
            end else begin
                exp_ack_rd[cyc+3] = 1'b1;
                exp_rd_at[cyc+3]  = model_mem[cpu_addr];
            end
        end
    endtask

    task automatic check_outputs();
        if (exp_dv[cyc])     exp_ddata  = exp_dd_at[cyc];
        if (exp_ack_rd[cyc]) exp_crdata = exp_rd_at[cyc];
        chk("disp_valid", 32'(disp_valid), 32'(exp_dv[cyc]));
        chk("disp_data", 32'(disp_data), 32'(exp_ddata));
        chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack[cyc]));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crdata));
        chk("ram_we", 32'(ram_we), 32'(exp_we_now));
        chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
        if (exp_we_now) chk("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
        chk("stall_count", 32'(stall_count), 32'(exp_stall));
    endtask

    task automatic step();
        @(posedge clk_pixel);
        model_edge();
        @(negedge clk_pixel);
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        #1;
        model_clear();
        check_outputs();
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        for (int i = 0; i < n; i++) step();
        @(negedge clk_pixel);
        reset_n = 1'b1;
    endtask

    // Holds a CPU request until ack; display is asserted for the first ndisp edges.
    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int ndisp, output int lat);
        int start;
        bit done;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        start = cyc + 1;
        done  = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            disp_req  = (i < ndisp);
            disp_addr = AW'($urandom_range(0, 15));
            step();
            if (cpu_ack) done = 1'b1;
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        lat = cyc - start;
        chk("cpu_op_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        int acks;
        model_clear();

        do_reset(2);

        // Display read of a location preloaded by a CPU write.
        cpu_op(1'b1, 13'h0020, 8'hA5, 0, lat);
        step();
        disp_req = 1'b1; disp_addr = 13'h0020;
        step();
        disp_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("disp_read_valid", 32'(disp_valid), 32'd1);
        chk("disp_read_data", 32'(disp_data), 32'hA5);
        step();

        // Display and CPU read collide on the same edge.
        cpu_op(1'b0, 13'h1000, 8'h00, 1, lat);
        chk("collision_latency", 32'(lat), 32'd4);
        step();

        // Write then read back at the top address.
        cpu_op(1'b1, 13'h1FFF, 8'h3C, 0, lat);
        chk("write_latency", 32'(lat), 32'd3);
        step();
        cpu_op(1'b0, 13'h1FFF, 8'h00, 0, lat);
        chk("read_latency", 32'(lat), 32'd3);
        chk("read_data", 32'(cpu_rdata), 32'h3C);
        step();

        // Starvation during a 5-cycle display burst.
        do_reset(1);
        cpu_op(1'b0, 13'h0020, 8'h00, 5, lat);
        chk("starve_latency", 32'(lat), 32'd8);
`ifdef VRAM_ARB_STALL_CNT_EN
        chk("starve_stall", 32'(stall_count), 32'd5);
`else
        chk("starve_stall", 32'(stall_count), 32'd0);
`endif
        step();

        // Reset one cycle after a CPU grant.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF;
        step();
        step();
        cpu_req = 1'b0;
        do_reset(2);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            acks += int'(cpu_ack);
        end
        chk("reset_no_ack", 32'(acks), 32'd0);

        // CPU request abandoned during a display burst.
        acks = 0;
        disp_req = 1'b1; disp_addr = 13'h0005;
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0005; cpu_wdata = 8'h77;
        step();
        cpu_req = 1'b0;
        step();
        disp_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            acks += int'(cpu_ack) + int'(ram_we);
        end
        chk("abandon_no_ack", 32'(acks), 32'd0);

        // Random traffic on a small address window so reads hit earlier writes.
        for (int i = 0; i < 1500; i++) begin
            disp_req  = ($urandom_range(0, 2) == 0);
            disp_addr = AW'($urandom_range(0, 15));
            if (!cpu_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    cpu_req   = 1'b1;
                    cpu_we    = 1'($urandom_range(0, 1));
                    cpu_addr  = AW'($urandom_range(0, 15));
                    cpu_wdata = DW'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_req = 1'b0;
            end
            if (i == 700) begin
                do_reset(1);
            end else begin
                step();
                if (cpu_ack) cpu_req = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
